riscv_test_monitor: RTL

//   Synthesizable pass/fail monitor for riscv-tests runs on Core. Watches the

---
 rtl/riscv_test_monitor.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: watches retiring PC and gp (x3) of the core, latches a
// sticky PASS/FAIL/TIMEOUT verdict when the test-end PC retires or the cycle
// budget runs out, and counts RUN cycles and retired instructions.
module riscv_test_monitor #(
  parameter int                  XLEN           = 32,
  parameter logic [XLEN-1:0]     END_PC         = 32'h44,
  parameter int                  TIMEOUT_CYCLES = 5000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              retire,
  input  logic [XLEN-1:0]   retire_pc,
  input  logic [XLEN-1:0]   gp_value,
  output logic              running,
  output logic              done,
  output logic              done_pulse,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [XLEN-2:0]   fail_test_num,
  output logic [31:0]       cycle_count,
  output logic [31:0]       retired_count
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  // cycle_count value on which the final allowed RUN edge occurs
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] CNT_MAX      = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] GP_PASS  = {{(XLEN-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic              running_q, running_d;
  logic              done_q, done_d;
  logic              done_pulse_q, done_pulse_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              timeout_q, timeout_d;
  logic [XLEN-2:0]   fail_test_num_q, fail_test_num_d;
  logic [31:0]       cycle_count_q, cycle_count_d;
  logic [31:0]       retired_count_q, retired_count_d;

  logic              end_hit;
  logic [31:0]       cycle_inc;
  logic [31:0]       retired_inc;

  // Saturating increments and end-of-test detection
  always_comb begin
    end_hit     = retire && (retire_pc == END_PC);
    cycle_inc   = (cycle_count_q == CNT_MAX) ? cycle_count_q : cycle_count_q + 32'd1;
    retired_inc = (retired_count_q == CNT_MAX) ? retired_count_q : retired_count_q + 32'd1;
  end

  // Next-state and registered-output logic; start always wins over a hit
  always_comb begin
    state_d         = state_q;
    done_d          = done_q;
    done_pulse_d    = 1'b0;
    pass_d          = pass_q;
    fail_d          = fail_q;
    timeout_d       = timeout_q;
    fail_test_num_d = fail_test_num_q;
    cycle_count_d   = cycle_count_q;
    retired_count_d = retired_count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d         = ST_RUN;
          cycle_count_d   = 32'd0;
          retired_count_d = 32'd0;
        end
      end
      ST_RUN: begin
        if (start) begin
          cycle_count_d   = 32'd0;
          retired_count_d = 32'd0;
        end else begin
          cycle_count_d = cycle_inc;
          if (retire) begin
            retired_count_d = retired_inc;
          end
          if (end_hit) begin
            done_d       = 1'b1;
            done_pulse_d = 1'b1;
            if (gp_value == GP_PASS) begin
              state_d = ST_PASS;
              pass_d  = 1'b1;
            end else begin
              state_d         = ST_FAIL;
              fail_d          = 1'b1;
              fail_test_num_d = gp_value[XLEN-1:1];
            end
          end else if (cycle_count_q == TIMEOUT_LAST) begin
            state_d      = ST_TIMEOUT;
            timeout_d    = 1'b1;
            done_d       = 1'b1;
            done_pulse_d = 1'b1;
          end
        end
      end
      ST_PASS, ST_FAIL, ST_TIMEOUT: begin
        // Terminal: counters frozen, only a new start leaves
        if (start) begin
          state_d         = ST_RUN;
          done_d          = 1'b0;
          pass_d          = 1'b0;
          fail_d          = 1'b0;
          timeout_d       = 1'b0;
          fail_test_num_d = '0;
          cycle_count_d   = 32'd0;
          retired_count_d = 32'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    running_d = (state_d == ST_RUN);
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      running_q       <= 1'b0;
      done_q          <= 1'b0;
      done_pulse_q    <= 1'b0;
      pass_q          <= 1'b0;
      fail_q          <= 1'b0;
      timeout_q       <= 1'b0;
      fail_test_num_q <= '0;
      cycle_count_q   <= 32'd0;
      retired_count_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      running_q       <= running_d;
      done_q          <= done_d;
      done_pulse_q    <= done_pulse_d;
      pass_q          <= pass_d;
      fail_q          <= fail_d;
      timeout_q       <= timeout_d;
      fail_test_num_q <= fail_test_num_d;
      cycle_count_q   <= cycle_count_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign running       = running_q;
  assign done          = done_q;
  assign done_pulse    = done_pulse_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign timeout       = timeout_q;
  assign fail_test_num = fail_test_num_q;
  assign cycle_count   = cycle_count_q;
  assign retired_count = retired_count_q;

endmodule
